// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the CRC receive path:
//   - default data width, CRC width and generator polynomial
//   - link-monitor state encoding
//   - xpow_mod(): constant function returning x^i mod divisor, used to build
//     the single-bit-error position table
// -----------------------------------------------------------------------------
package crc_pkg;

  localparam int         BW_DEF      = 4;
  localparam int         CRC_BW_DEF  = 3;
  localparam logic [3:0] DIVISOR_DEF = 4'b1011;

  typedef enum logic [1:0] {
    LOST    = 2'd0,
    LOCKED  = 2'd1,
    SUSPECT = 2'd2
  } mon_state_e;

  // Remainder of the monomial x^i divided by the generator. The syndrome of a
  // codeword with only bit i flipped equals this value, which is what makes
  // single-bit correction a table lookup.
  function automatic logic [31:0] xpow_mod(input int i, input logic [32:0] divisor,
                                           input int crc_bw);
    logic [32:0] r;
    r = 33'd1;
    for (int k = 0; k < i; k++) begin
      r = r << 1;
      if (r[crc_bw]) r = r ^ divisor;
    end
    return r[31:0];
  endfunction

endpackage

// File: rtl/crc_syndrome.sv
// -----------------------------------------------------------------------------
// crc_syndrome
// Combinational polynomial remainder: syndrome_o = word_i mod DIVISOR (GF(2)).
// Also usable on the transmit side by feeding {data, 0}.
// Ports:
//   word_i      in  BW+CRC_BW  word to divide, MSB = highest power
//   syndrome_o  out CRC_BW     remainder
// -----------------------------------------------------------------------------
module crc_syndrome
  import crc_pkg::*;
#(
  parameter int              BW      = BW_DEF,
  parameter int              CRC_BW  = CRC_BW_DEF,
  parameter logic [CRC_BW:0] DIVISOR = DIVISOR_DEF
) (
  input  logic [BW+CRC_BW-1:0] word_i,
  output logic [CRC_BW-1:0]    syndrome_o
);

  // Bit-serial long division unrolled across the word, MSB first.
  always_comb begin : div
    logic [CRC_BW-1:0] rem;
    logic [CRC_BW:0]   acc;
    // NOTE: every combinational variable gets a value before any branch, so
    // no path can leave it unassigned and infer a latch.
    rem = '0;
    acc = '0;
    for (int i = BW + CRC_BW - 1; i >= 0; i--) begin
      acc = {rem, word_i[i]};
      if (acc[CRC_BW]) acc = acc ^ DIVISOR;
      rem = acc[CRC_BW-1:0];
    end
    syndrome_o = rem;
  end

endmodule

// File: rtl/crc_receiver.sv
// -----------------------------------------------------------------------------
// crc_receiver
// Two-stage CRC check of {data, crc} codewords with a saturating error counter
// and a LOST/LOCKED/SUSPECT link monitor. Fixed 2-cycle latency, one word per
// cycle, no backpressure.
// Optional feature: define CRC_CORRECT_EN to repair single-bit errors via a
// syndrome-to-position table; otherwise corrected_o is tied 0 and no lookup
// logic exists.
// Ports:
//   clk        in   clock
//   rstn       in   synchronous active-low reset
//   in_valid   in   codeword qualifier
//   in         in   BW+CRC_BW codeword, data in the MSBs
//   cnt_clr    in   synchronous clear of err_cnt (wins over increment)
//   out_valid  out  out/crc_err/corrected valid
//   out        out  BW recovered data (held while out_valid=0)
//   crc_err    out  non-zero, uncorrected syndrome
//   corrected  out  single-bit error repaired
//   locked     out  monitor in LOCKED or SUSPECT
//   err_cnt    out  CNT_W saturating count of crc_err words
// -----------------------------------------------------------------------------
module crc_receiver
  import crc_pkg::*;
#(
  parameter int              BW          = BW_DEF,
  parameter int              CRC_BW      = CRC_BW_DEF,
  parameter logic [CRC_BW:0] DIVISOR     = DIVISOR_DEF,
  parameter int              ERR_THRESH  = 3,
  parameter int              GOOD_THRESH = 4,
  parameter int              CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [BW+CRC_BW-1:0] in,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  output logic [BW-1:0]        out,
  output logic                 crc_err,
  output logic                 corrected,
  output logic                 locked,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int CW      = BW + CRC_BW;
  localparam int RUN_MAX = (ERR_THRESH > GOOD_THRESH) ? ERR_THRESH : GOOD_THRESH;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  // ---------------------------------------------------------------------------
  // Stage 1: register the incoming word
  // ---------------------------------------------------------------------------
  logic          s1_valid_q;
  logic [CW-1:0] s1_word_q;

  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled on the clock edge only (synchronous), so it
    // sits inside the clocked branch rather than in the sensitivity list.
    if (!rstn) begin
      // NOTE: sequential state is always written with <= so every flop samples
      // the pre-edge values of its neighbours.
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_word_q  <= in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: syndrome and decode
  // ---------------------------------------------------------------------------
  logic [CRC_BW-1:0] syndrome;
  logic [BW-1:0]     data_d;
  logic              err_d;
  logic              corr_d;

  crc_syndrome #(
    .BW      (BW),
    .CRC_BW  (CRC_BW),
    .DIVISOR (DIVISOR)
  ) u_syndrome (
    .word_i     (s1_word_q),
    .syndrome_o (syndrome)
  );

`ifdef CRC_CORRECT_EN
  // Entry i holds the syndrome produced by a lone error in codeword bit i.
  function automatic logic [CW*CRC_BW-1:0] build_pos_tbl();
    logic [CW*CRC_BW-1:0] t;
    t = '0;
    for (int i = 0; i < CW; i++) begin
      t[i*CRC_BW +: CRC_BW] = CRC_BW'(xpow_mod(i, 33'(DIVISOR), CRC_BW));
    end
    return t;
  endfunction

  localparam logic [CW*CRC_BW-1:0] POS_TBL = build_pos_tbl();

  always_comb begin : decode
    int unsigned   match_cnt;
    int unsigned   match_pos;
    logic [CW-1:0] fixed;
    match_cnt = 0;
    match_pos = 0;
    fixed     = s1_word_q;
    data_d    = s1_word_q[CW-1:CRC_BW];
    err_d     = (syndrome != '0);
    corr_d    = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (syndrome == POS_TBL[i*CRC_BW +: CRC_BW]) begin
        match_cnt = match_cnt + 1;
        match_pos = i;
      end
    end
    // Only an unambiguous match is trusted; a flip in a CRC bit still counts
    // as a repair even though the data bits are unchanged.
    if (syndrome != '0 && match_cnt == 1) begin
      fixed  = s1_word_q ^ (CW'(1) << match_pos);
      data_d = fixed[CW-1:CRC_BW];
      err_d  = 1'b0;
      corr_d = 1'b1;
    end
  end
`else
  always_comb begin : decode
    data_d = s1_word_q[CW-1:CRC_BW];
    err_d  = (syndrome != '0);
    corr_d = 1'b0;
  end
`endif

  logic          out_valid_q;
  logic [BW-1:0] out_q;
  logic          crc_err_q;
  logic          corrected_q;

  // Data/flag registers load only on a valid word so they hold between words.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      crc_err_q   <= 1'b0;
      corrected_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q       <= data_d;
        crc_err_q   <= err_d;
        corrected_q <= corr_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter; updates alongside the S2 output registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (s1_valid_q && err_d && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Link monitor: state advances on the same edge that presents the word, and
  // locked is taken from the next state so it moves together with out_valid.
  // ---------------------------------------------------------------------------
  mon_state_e       state_q, state_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [RUN_W-1:0] err_run_q, err_run_d;
  logic             locked_q;

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    err_run_d  = err_run_q;
    if (s1_valid_q) begin
      unique case (state_q)
        LOST: begin
          if (err_d) begin
            good_run_d = '0;
          end else if (good_run_q + RUN_W'(1) == RUN_W'(GOOD_THRESH)) begin
            state_d    = LOCKED;
            good_run_d = '0;
          end else begin
            good_run_d = good_run_q + RUN_W'(1);
          end
        end
        LOCKED: begin
          if (err_d) begin
            state_d   = SUSPECT;
            err_run_d = RUN_W'(1);
          end
        end
        SUSPECT: begin
          if (!err_d) begin
            state_d   = LOCKED;
            err_run_d = '0;
          end else if (err_run_q + RUN_W'(1) == RUN_W'(ERR_THRESH)) begin
            state_d   = LOST;
            err_run_d = '0;
          end else begin
            err_run_d = err_run_q + RUN_W'(1);
          end
        end
        default: begin
          state_d    = LOST;
          good_run_d = '0;
          err_run_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= LOST;
      good_run_q <= '0;
      err_run_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      err_run_q  <= err_run_d;
      locked_q   <= (state_d != LOST);
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign crc_err   = crc_err_q;
  assign corrected = corrected_q;
  assign locked    = locked_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/crc_receiver.md
Name: crc_receiver

Overview:
- Downstream stage of the CRC transmitter. Takes the {data, CRC} codeword, divides it by the same generator polynomial, and delivers the data word with an error flag.
- Keeps a saturating error counter and a lock/loss link-monitor state machine that reports link health.
- Sits between the channel model and the data sink. Fixed 2-cycle latency; no backpressure.

Parameters:
- BW, 4, data width in bits.
- CRC_BW, 3, CRC width in bits.
- DIVISOR, 4'b1011, generator polynomial, CRC_BW+1 bits, MSB always 1.
- ERR_THRESH, 3, consecutive bad words that take the monitor from SUSPECT to LOST (≥2).
- GOOD_THRESH, 4, consecutive good words that take the monitor from LOST to LOCKED (≥1).
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- in_valid  in  1  codeword qualifier.
- in  in  BW+CRC_BW  codeword {data, crc}, data in the MSBs.
- cnt_clr  in  1  synchronous clear of err_cnt.
- out_valid  out  1  out, crc_err and corrected are valid.
- out  out  BW  recovered data.
- crc_err  out  1  uncorrectable or non-zero syndrome.
- corrected  out  1  single-bit error repaired; tied 0 without the macro.
- locked  out  1  monitor is in LOCKED or SUSPECT.
- err_cnt  out  CNT_W  saturating count of crc_err words.

Behaviour:
- Reset:
  - Clocked by clk; reset rstn is synchronous, active-low.
  - On reset: all outputs 0, pipeline valids 0, monitor state LOST, run counters 0.
- Pipeline:
  - S1 registers in and in_valid.
  - S2 computes the syndrome from S1 as remainder(in mod DIVISOR), CRC_BW bits, and registers the outputs.
  - out_valid is in_valid delayed by 2 cycles. Back-to-back words are accepted every cycle.
- Outputs for each word:
  - syndrome==0 → out=in[top BW bits], crc_err=0.
  - syndrome!=0 → crc_err=1. out carries the raw data bits unless the word is corrected (see Optional Feature).
  - out, crc_err and corrected hold their values while out_valid=0.
- Error counter:
  - err_cnt increments on each out_valid&&crc_err and saturates at 2^CNT_W-1.
  - cnt_clr has priority: a clear in the same cycle as an error gives 0.
- Monitor FSM, evaluated only on S2 words (out_valid). A "good" word has crc_err=0; corrected words are good.
  - LOST:
    - good → good_run+1.
    - When good_run reaches GOOD_THRESH → LOCKED, good_run=0.
    - bad → good_run=0.
  - LOCKED:
    - bad → SUSPECT, err_run=1.
    - good → stay.
  - SUSPECT:
    - good → LOCKED, err_run=0.
    - bad → err_run+1. When err_run reaches ERR_THRESH → LOST, err_run=0.
  - locked is registered from the next-state value, so it updates in the same cycle as out_valid.
- Reset mid-stream: in-flight words are dropped, no out_valid, and the monitor returns to LOST.

Optional Feature:
- Macro: CRC_CORRECT_EN.
- Defined:
  - The S2 syndrome is matched against x^i mod DIVISOR for i=0..BW+CRC_BW-1 (position table built as a constant).
  - Unique match → flip bit i, corrected=1, crc_err=0.
  - No match → crc_err=1, data uncorrected.
- Undefined:
  - Any non-zero syndrome → crc_err=1 and corrected=0.
  - No lookup logic is synthesised.

Decomposition:
- Package crc_pkg holds:
  - default BW, CRC_BW and DIVISOR constants;
  - the monitor state enum {LOST, LOCKED, SUSPECT};
  - a constant function returning x^i mod DIVISOR, used for the correction table.
- Sub-module crc_syndrome (combinational polynomial remainder, parameterised by BW, CRC_BW and DIVISOR).
- The transmitter may reuse crc_syndrome by feeding it {data, 0}.

Test Plan:
- Reset, then 4 clean codewords 7'h4E, 7'h00, 7'h7F, 7'h4E:
  - out = 4'h9, 4'h0, 4'hF, 4'h9, 2 cycles after each input.
  - crc_err=0.
  - locked rises with the 4th out_valid.
- While locked, send 7'h4F (bit 0 flipped):
  - Without macro: crc_err=1, err_cnt=1, locked stays 1 (SUSPECT).
  - With macro: out=4'h9, corrected=1, crc_err=0.
- With macro, send 7'h6E (bit 5 flipped) → syndrome 3'b111, out=4'h9, corrected=1.
- Without macro, send 3 consecutive 7'h4F after lock:
  - locked falls on the 3rd.
  - Then 4 clean words relock.
  - err_cnt=3.
- Drive 260 bad words with CNT_W=8 → err_cnt saturates at 255. Assert cnt_clr in the same cycle as a bad word → err_cnt=0.
- Assert rstn=0 mid-stream with 2 words in flight:
  - No out_valid follows.
  - Outputs 0, locked=0.
